// File: rtl/fft_pitch_tracker.sv
// fft_pitch_tracker: searches each FFT frame of magnitude-squared bins for the
// strongest bin in [K_MIN, K_MAX]. It publishes that bin as a pitch once
// N_CONFIRM consecutive voiced frames have peaks within TOL bins of each other.
// Incoming bins pass through one input register before the peak search. The
// result therefore loads two edges after the edge that samples the last bin:
// one edge to finish the search and enter DECIDE, and one edge to end DECIDE.
module fft_pitch_tracker #(
  parameter int unsigned W         = 33,
  parameter int unsigned NSamples  = 1024,
  parameter int unsigned K_MIN     = 1,
  parameter int unsigned K_MAX     = 511,
  parameter int unsigned THRESH    = 1024,
  parameter int unsigned N_CONFIRM = 3,
  parameter int unsigned TOL       = 2,
  localparam int unsigned KW       = $clog2(NSamples)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  mag,
  input  logic          mag_valid,
  output logic [KW-1:0] pitch_data,
  output logic          pitch_valid,
  input  logic          pitch_ready,
  output logic [W-1:0]  peak_mag,
  output logic          voiced,
  output logic          frame_done,
  output logic          overrun
);

  localparam logic [KW-1:0] LAST_K = KW'(NSamples - 1);
  localparam logic [KW-1:0] KMIN_K = KW'(K_MIN);
  localparam logic [KW-1:0] KMAX_K = KW'(K_MAX);
  localparam logic [KW:0]   TOL_D  = (KW+1)'(TOL);
  localparam logic [3:0]    NCONF  = 4'(N_CONFIRM);
  localparam logic [W-1:0]  THR    = W'(THRESH);

  typedef enum logic {ACCUM, DECIDE} state_t;

  state_t        r_state;
  logic          r_in_v;
  logic [W-1:0]  r_in_mag;
  logic [KW-1:0] r_k;
  logic [KW-1:0] r_best_k;
  logic [W-1:0]  r_best_mag;
  logic [KW-1:0] r_prev_k;
  logic          r_prev_ok;
  logic [3:0]    r_cnt;
  logic [W-1:0]  r_peak_mag;
  logic          r_voiced;
  logic          r_frame_done;
  logic [KW-1:0] r_pitch_data;
  logic          r_pitch_valid;
  logic          r_overrun;

  logic          w_in_range;
  logic          w_last;
  logic          w_voiced;
  logic [KW:0]   w_dist;
  logic          w_consistent;
  logic [3:0]    w_cnt_next;
  logic          w_publish;

  assign w_in_range = (r_k >= KMIN_K) && (r_k <= KMAX_K);
  assign w_last     = r_in_v && (r_k == LAST_K);
  assign w_voiced   = (r_best_mag >= THR);

  // Unsigned absolute bin distance, one bit wider than a bin index so it cannot wrap
  always_comb begin
    w_dist = '0;
    if ({1'b0, r_best_k} >= {1'b0, r_prev_k})
      w_dist = {1'b0, r_best_k} - {1'b0, r_prev_k};
    else
      w_dist = {1'b0, r_prev_k} - {1'b0, r_best_k};
  end

  assign w_consistent = r_prev_ok && (w_dist <= TOL_D);

  // Next confirmation count for the frame being decided
  always_comb begin
    w_cnt_next = '0;
    if (w_voiced) begin
      if (w_consistent)
        w_cnt_next = (r_cnt >= NCONF) ? NCONF : r_cnt + 4'd1;
      else
        w_cnt_next = 4'd1;
    end
  end

  assign w_publish = (r_state == DECIDE) && w_voiced && (w_cnt_next >= NCONF);

  // Input register: one bin per mag_valid, no back-pressure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_v   <= 1'b0;
      r_in_mag <= '0;
    end else begin
      r_in_v   <= mag_valid;
      r_in_mag <= mag;
    end
  end

  // Bin counter, frame FSM and running-peak search
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ACCUM;
      r_k          <= '0;
      r_best_k     <= KMIN_K;
      r_best_mag   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_in_v)
        r_k <= r_k + 1'b1;
      case (r_state)
        ACCUM: begin
          if (r_in_v && w_in_range && (r_in_mag > r_best_mag)) begin
            r_best_mag <= r_in_mag;
            r_best_k   <= r_k;
          end
          if (w_last) begin
            r_state      <= DECIDE;
            r_frame_done <= 1'b1;
          end
        end
        DECIDE: begin
          // The peak restarts here, and a bin landing in DECIDE is bin 0 of the new frame
          r_state <= ACCUM;
          if (r_in_v && w_in_range && (r_in_mag != '0)) begin
            r_best_mag <= r_in_mag;
            r_best_k   <= r_k;
          end else begin
            r_best_mag <= '0;
            r_best_k   <= KMIN_K;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  // Per-frame decision: frame outputs, confirmation count and previous peak
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_peak_mag <= '0;
      r_voiced   <= 1'b0;
      r_cnt      <= '0;
      r_prev_k   <= '0;
      r_prev_ok  <= 1'b0;
    end else if (r_state == DECIDE) begin
      r_peak_mag <= r_best_mag;
      r_voiced   <= w_voiced;
      r_cnt      <= w_cnt_next;
      r_prev_ok  <= w_voiced;
      if (w_voiced)
        r_prev_k <= r_best_k;
    end
  end

  // Pitch output handshake; a new publish wins over a same-edge accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pitch_data  <= '0;
      r_pitch_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else if (w_publish) begin
      r_pitch_data  <= r_best_k;
      r_pitch_valid <= 1'b1;
      if (r_pitch_valid && !pitch_ready)
        r_overrun <= 1'b1;
    end else if (r_pitch_valid && pitch_ready) begin
      r_pitch_valid <= 1'b0;
    end
  end

  assign pitch_data  = r_pitch_data;
  assign pitch_valid = r_pitch_valid;
  assign peak_mag    = r_peak_mag;
  assign voiced      = r_voiced;
  assign frame_done  = r_frame_done;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_fft_pitch_tracker.sv
// Directed bench for fft_pitch_tracker using a 16-bin frame. Expected values
// are worked out by hand from the frame contents.
module tb_fft_pitch_tracker;

  localparam int unsigned W  = 16;
  localparam int unsigned KW = 4;

  logic          clk;
  logic          reset;
  logic [W-1:0]  mag;
  logic          mag_valid;
  logic [KW-1:0] pitch_data;
  logic          pitch_valid;
  logic          pitch_ready;
  logic [W-1:0]  peak_mag;
  logic          voiced;
  logic          frame_done;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  fft_pitch_tracker #(
    .W(W), .NSamples(16), .K_MIN(1), .K_MAX(7),
    .THRESH(100), .N_CONFIRM(2), .TOL(1)
  ) dut (
    .clk(clk), .reset(reset), .mag(mag), .mag_valid(mag_valid),
    .pitch_data(pitch_data), .pitch_valid(pitch_valid), .pitch_ready(pitch_ready),
    .peak_mag(peak_mag), .voiced(voiced), .frame_done(frame_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sends bins 0..n-1 with value m1 at bin p1, m2 at bin p2, zero elsewhere.
  // Each bin may be preceded by up to gap_max idle cycles.
  task automatic send_bins(input int n, input int p1, input int m1, input int p2,
                           input int m2, input int gap_max);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      mag_valid = 1'b0;
      repeat (g) begin
        @(posedge clk); #1;
      end
      mag       = (i == p1) ? W'(m1) : (i == p2) ? W'(m2) : '0;
      mag_valid = 1'b1;
      @(posedge clk); #1;
    end
    mag_valid = 1'b0;
  endtask

  // Observes the frame_done pulse and the decision outputs that follow it.
  // Called right after the last bin has been sampled.
  task automatic finish_frame(input string tag, input int exp_peak, input int exp_voiced,
                              input int exp_pub, input int exp_data, input int ready_mid);
    @(posedge clk); #1;
    chk({tag, ".frame_done"}, 32'(frame_done), 32'd1);
    if (ready_mid != 0) pitch_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".done_low"}, 32'(frame_done), 32'd0);
    chk({tag, ".peak_mag"}, 32'(peak_mag), 32'(exp_peak));
    chk({tag, ".voiced"}, 32'(voiced), 32'(exp_voiced));
    chk({tag, ".pitch_valid"}, 32'(pitch_valid), 32'(exp_pub));
    if (exp_pub != 0) chk({tag, ".pitch_data"}, 32'(pitch_data), 32'(exp_data));
  endtask

  initial begin
    reset       = 1'b0;
    mag         = '0;
    mag_valid   = 1'b0;
    pitch_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pitch_valid", 32'(pitch_valid), 32'd0);
    chk("rst.pitch_data", 32'(pitch_data), 32'd0);
    chk("rst.peak_mag", 32'(peak_mag), 32'd0);
    chk("rst.voiced", 32'(voiced), 32'd0);
    chk("rst.frame_done", 32'(frame_done), 32'd0);
    chk("rst.overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Bin 12 lies outside [1,7]; the peak is bin 3. Voiced, count 1, nothing published.
    send_bins(16, 3, 500, 12, 900, 0);
    finish_frame("range", 500, 1, 0, 0, 0);

    // An all-zero frame gives magnitude 0, unvoiced, and clears the count.
    send_bins(16, -1, 0, -1, 0, 0);
    finish_frame("zero", 0, 0, 0, 0, 0);

    // Peaks at bin 3 then bin 4 are within TOL, so the second frame publishes 4.
    send_bins(16, 3, 500, -1, 0, 0);
    finish_frame("conf1", 500, 1, 0, 0, 0);
    send_bins(16, 4, 500, -1, 0, 0);
    finish_frame("conf2", 500, 1, 1, 4, 0);
    @(posedge clk); #1;
    chk("conf2.accepted", 32'(pitch_valid), 32'd0);
    // A peak at bin 6 is 2 bins away, so the count restarts at 1.
    send_bins(16, 6, 500, -1, 0, 0);
    finish_frame("conf3", 500, 1, 0, 0, 0);

    // Tied peaks below threshold: unvoiced with magnitude 80.
    send_bins(16, 2, 80, 5, 80, 0);
    finish_frame("unv", 80, 0, 0, 0, 0);
    // Tied at 300: lower bin 2 wins, and a following bin-2 frame publishes 2.
    send_bins(16, 2, 300, 5, 300, 0);
    finish_frame("tie1", 300, 1, 0, 0, 0);
    send_bins(16, 2, 300, -1, 0, 0);
    finish_frame("tie2", 300, 1, 1, 2, 0);
    @(posedge clk); #1;

    // Back-pressure after a clearing unvoiced frame.
    send_bins(16, -1, 0, -1, 0, 0);
    finish_frame("bp0", 0, 0, 0, 0, 0);
    pitch_ready = 1'b0;
    send_bins(16, 3, 500, -1, 0, 0);
    finish_frame("bp1", 500, 1, 0, 0, 0);
    send_bins(16, 3, 500, -1, 0, 0);
    finish_frame("bp2", 500, 1, 1, 3, 0);
    chk("bp2.overrun", 32'(overrun), 32'd0);
    send_bins(16, 3, 500, -1, 0, 0);
    chk("bp.held_valid", 32'(pitch_valid), 32'd1);
    chk("bp.held_data", 32'(pitch_data), 32'd3);
    finish_frame("bp3", 500, 1, 1, 3, 0);
    chk("bp3.overrun", 32'(overrun), 32'd1);
    // Ready rises on the edge that publishes bin 4: the new value loads and stays valid.
    send_bins(16, 4, 500, -1, 0, 0);
    finish_frame("bp4", 500, 1, 1, 4, 1);
    chk("bp4.overrun_sticky", 32'(overrun), 32'd1);
    @(posedge clk); #1;
    chk("bp4.accepted", 32'(pitch_valid), 32'd0);

    // Reset partway through a frame discards it; all outputs return to 0.
    send_bins(9, 3, 500, -1, 0, 0);
    mag       = W'(200);
    mag_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid.pitch_data", 32'(pitch_data), 32'd0);
    chk("mid.peak_mag", 32'(peak_mag), 32'd0);
    chk("mid.voiced", 32'(voiced), 32'd0);
    chk("mid.overrun", 32'(overrun), 32'd0);
    mag_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid.frame_done", 32'(frame_done), 32'd0);
    chk("mid.pitch_valid", 32'(pitch_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    send_bins(16, 5, 700, -1, 0, 0);
    finish_frame("post_rst", 700, 1, 0, 0, 0);

    // Random idle cycles between bins do not change the result.
    send_bins(16, 5, 700, -1, 0, 3);
    finish_frame("gap", 700, 1, 1, 5, 0);
    @(posedge clk); #1;

    // Back-to-back frames: bin 0 of the second frame arrives during DECIDE.
    send_bins(16, 5, 700, -1, 0, 0);
    send_bins(16, 4, 500, -1, 0, 0);
    finish_frame("b2b", 500, 1, 1, 4, 0);
    @(posedge clk); #1;
    chk("b2b.accepted", 32'(pitch_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
